// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared opcodes, functs, ALU/FSM enums and control word for the
//               multicycle MIPS core. MIPS_SHIFT_EN adds sll and srlv.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

   localparam int MEM_DEPTH = 1024;
   localparam int MEM_AW    = 10;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_AND  = 3'd2,
      ALU_OR   = 3'd3,
      ALU_SLT  = 3'd4,
      ALU_SLL  = 3'd5,
      ALU_SRL  = 3'd6,
      ALU_NONE = 3'd7
   } alu_op_e;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXECUTE  = 4'd6,
      ST_ALUWB    = 4'd7,
      ST_ADDIEXEC = 4'd8,
      ST_ADDIWB   = 4'd9,
      ST_BEQ      = 4'd10,
      ST_JUMP     = 4'd11
   } state_e;

   typedef enum logic [1:0] {
      PC_ALU    = 2'd0,
      PC_ALUOUT = 2'd1,
      PC_JUMP   = 2'd2
   } pc_src_e;

   typedef enum logic {
      ALUA_PC  = 1'b0,
      ALUA_REG = 1'b1
   } alu_a_e;

   typedef enum logic [1:0] {
      ALUB_REG = 2'd0,
      ALUB_ONE = 2'd1,
      ALUB_IMM = 2'd2
   } alu_b_e;

   typedef struct packed {
      logic    ir_we;
      logic    pc_we;
      logic    pc_cond;
      pc_src_e pc_src;
      alu_a_e  alu_a;
      alu_b_e  alu_b;
      alu_op_e alu_op;
      logic    ab_we;
      logic    aluout_we;
      logic    mem_addr_alu;
      logic    mdr_we;
      logic    mem_we;
      logic    rf_we;
      logic    rf_dst_rd;
      logic    rf_from_mem;
   } ctrl_t;

   // ALU_NONE marks an unsupported funct, which retires without any write.
   function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
      alu_op_e op;
      op = ALU_NONE;
      case (funct)
         FN_ADD:  op = ALU_ADD;
         FN_SUB:  op = ALU_SUB;
         FN_AND:  op = ALU_AND;
         FN_OR:   op = ALU_OR;
         FN_SLT:  op = ALU_SLT;
`ifdef MIPS_SHIFT_EN
         FN_SLL:  op = ALU_SLL;
         FN_SRLV: op = ALU_SRL;
`endif
         default: op = ALU_NONE;
      endcase
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_control.sv
// ============================================================================
// Module      : control_unit
// Description : Two-process control FSM sequencing the shared datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output ctrl_t      ctrl
);

   state_e  state_q;
   state_e  state_d;
   alu_op_e fn_op;

   assign fn_op = funct_to_alu(funct);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_FETCH;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      ctrl        = '0;
      ctrl.alu_op = ALU_ADD;
      case (state_q)
         ST_FETCH: begin
            ctrl.ir_we  = 1'b1;
            ctrl.pc_we  = 1'b1;
            ctrl.pc_src = PC_ALU;
            ctrl.alu_a  = ALUA_PC;
            ctrl.alu_b  = ALUB_ONE;
            state_d     = ST_DECODE;
         end
         ST_DECODE: begin
            // Branch target is formed here while the ALU is otherwise idle.
            ctrl.ab_we     = 1'b1;
            ctrl.aluout_we = 1'b1;
            ctrl.alu_a     = ALUA_PC;
            ctrl.alu_b     = ALUB_IMM;
            case (op)
               OP_RTYPE:     state_d = (fn_op == ALU_NONE) ? ST_FETCH : ST_EXECUTE;
               OP_LW, OP_SW: state_d = ST_MEMADR;
               OP_ADDI:      state_d = ST_ADDIEXEC;
               OP_BEQ:       state_d = ST_BEQ;
               OP_J:         state_d = ST_JUMP;
               default:      state_d = ST_FETCH;
            endcase
         end
         ST_MEMADR: begin
            ctrl.alu_a     = ALUA_REG;
            ctrl.alu_b     = ALUB_IMM;
            ctrl.aluout_we = 1'b1;
            state_d        = (op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
         end
         ST_MEMREAD: begin
            ctrl.mem_addr_alu = 1'b1;
            ctrl.mdr_we       = 1'b1;
            state_d           = ST_MEMWB;
         end
         ST_MEMWB: begin
            ctrl.rf_we       = 1'b1;
            ctrl.rf_from_mem = 1'b1;
            state_d          = ST_FETCH;
         end
         ST_MEMWRITE: begin
            ctrl.mem_addr_alu = 1'b1;
            ctrl.mem_we       = 1'b1;
            state_d           = ST_FETCH;
         end
         ST_EXECUTE: begin
            ctrl.alu_a     = ALUA_REG;
            ctrl.alu_b     = ALUB_REG;
            ctrl.alu_op    = fn_op;
            ctrl.aluout_we = 1'b1;
            state_d        = ST_ALUWB;
         end
         ST_ALUWB: begin
            ctrl.rf_we     = 1'b1;
            ctrl.rf_dst_rd = 1'b1;
            state_d        = ST_FETCH;
         end
         ST_ADDIEXEC: begin
            ctrl.alu_a     = ALUA_REG;
            ctrl.alu_b     = ALUB_IMM;
            ctrl.aluout_we = 1'b1;
            state_d        = ST_ADDIWB;
         end
         ST_ADDIWB: begin
            ctrl.rf_we = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_BEQ: begin
            ctrl.alu_a   = ALUA_REG;
            ctrl.alu_b   = ALUB_REG;
            ctrl.alu_op  = ALU_SUB;
            ctrl.pc_cond = 1'b1;
            ctrl.pc_src  = PC_ALUOUT;
            state_d      = ST_FETCH;
         end
         ST_JUMP: begin
            ctrl.pc_we  = 1'b1;
            ctrl.pc_src = PC_JUMP;
            state_d     = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_datapath.sv
// ============================================================================
// Module      : mips_multicycle_mem / mips_multicycle_datapath
// Description : Unified 1024x32 memory and the shared multicycle datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_mem
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [MEM_AW-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   // Contents survive reset; programs are loaded through this array.
   logic [31:0] mem_space [0:MEM_DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) mem_space[addr] <= wdata;
   end

   assign rdata = mem_space[addr];

endmodule

module mips_multicycle_datapath
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  ctrl_t      ctrl,
   output logic [5:0] op,
   output logic [5:0] funct
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] aluout_q, aluout_d;
   logic [31:0] mdr_q, mdr_d;
   logic [31:0] regs_q [0:31];
   logic [31:0] regs_d [0:31];

   logic [4:0]        rs, rt, rd, shamt, wr_addr;
   logic [31:0]       simm, alu_a, alu_b, alu_y, wr_data, mem_rdata;
   logic              alu_zero, mem_we;
   logic [MEM_AW-1:0] mem_addr;

   assign op    = ir_q[31:26];
   assign funct = ir_q[5:0];
   assign rs    = ir_q[25:21];
   assign rt    = ir_q[20:16];
   assign rd    = ir_q[15:11];
   assign shamt = ir_q[10:6];
   assign simm  = {{16{ir_q[15]}}, ir_q[15:0]};

   assign alu_a = (ctrl.alu_a == ALUA_PC) ? pc_q : a_q;

   always_comb begin
      alu_b = b_q;
      case (ctrl.alu_b)
         ALUB_ONE: alu_b = 32'd1;
         ALUB_IMM: alu_b = simm;
         default:  alu_b = b_q;
      endcase
   end

   always_comb begin
      alu_y = '0;
      case (ctrl.alu_op)
         ALU_ADD:  alu_y = alu_a + alu_b;
         ALU_SUB:  alu_y = alu_a - alu_b;
         ALU_AND:  alu_y = alu_a & alu_b;
         ALU_OR:   alu_y = alu_a | alu_b;
         ALU_SLT:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
         ALU_SLL:  alu_y = alu_b << shamt;
         ALU_SRL:  alu_y = alu_b >> alu_a[4:0];
         default:  alu_y = '0;
      endcase
   end

   assign alu_zero = (alu_y == 32'd0);

   // Qualifying with rst keeps a write from landing while reset is held.
   assign mem_addr = ctrl.mem_addr_alu ? aluout_q[MEM_AW-1:0] : pc_q[MEM_AW-1:0];
   assign mem_we   = ctrl.mem_we & rst;

   mips_multicycle_mem RAM (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (b_q),
      .rdata (mem_rdata)
   );

   assign wr_addr = ctrl.rf_dst_rd   ? rd    : rt;
   assign wr_data = ctrl.rf_from_mem ? mdr_q : aluout_q;

   always_comb begin
      pc_d = pc_q;
      if (ctrl.pc_we || (ctrl.pc_cond && alu_zero)) begin
         case (ctrl.pc_src)
            PC_ALU:    pc_d = alu_y;
            PC_ALUOUT: pc_d = aluout_q;
            PC_JUMP:   pc_d = {pc_q[31:26], ir_q[25:0]};
            default:   pc_d = pc_q;
         endcase
      end
      ir_d     = ctrl.ir_we     ? mem_rdata  : ir_q;
      a_d      = ctrl.ab_we     ? regs_q[rs] : a_q;
      b_d      = ctrl.ab_we     ? regs_q[rt] : b_q;
      aluout_d = ctrl.aluout_we ? alu_y      : aluout_q;
      mdr_d    = ctrl.mdr_we    ? mem_rdata  : mdr_q;
   end

   // $0 is never written, so it reads as zero from reset onward.
   always_comb begin
      regs_d = regs_q;
      if (ctrl.rf_we && (wr_addr != 5'd0)) regs_d[wr_addr] = wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         aluout_q <= '0;
         mdr_q    <= '0;
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else begin
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         aluout_q <= aluout_d;
         mdr_q    <= mdr_d;
         for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
      end
   end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle.sv
// ============================================================================
// Module      : mips_multicycle
// Description : Multicycle MIPS-subset CPU top; `define MIPS_SHIFT_EN for sll/srlv.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle
   import mips_pkg::*;
(
   input  logic clk,
   input  logic rst
);

   ctrl_t      ctrl;
   logic [5:0] op;
   logic [5:0] funct;

   control_unit CU (
      .clk   (clk),
      .rst   (rst),
      .op    (op),
      .funct (funct),
      .ctrl  (ctrl)
   );

   mips_multicycle_datapath DP (
      .clk   (clk),
      .rst   (rst),
      .ctrl  (ctrl),
      .op    (op),
      .funct (funct)
   );

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle.sv
// ============================================================================
// Module      : tb_mips_multicycle
// Description : Self-checking bench: vector table, ISA-level reference model
//               with random programs, and hand-written timing/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle;
   import mips_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;

   mips_multicycle dut (
      .clk (clk),
      .rst (rst)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] HALT = 32'h1000FFFF;

   int checks = 0;
   int errors = 0;

   logic [31:0] img   [0:1023];
   logic [31:0] m_mem [0:1023];
   logic [31:0] m_reg [0:31];
   logic [31:0] m_pc;

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] instr;
      int          dst;
      logic [31:0] exp;
      int          cyc;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] in_fetch();
      return {31'd0, dut.CU.state_q == ST_FETCH};
   endfunction

   task automatic clear_img();
      for (int i = 0; i < 1024; i++) img[i] = 32'd0;
   endtask

   // Reset, backdoor-load the image, release; next posedge is the first FETCH.
   task automatic start_prog();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 1024; i++) dut.DP.RAM.mem_space[i] = img[i];
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] sx(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   // Instruction-level reference: executes until pc reaches halt, summing CPI.
   task automatic model_run(input int halt, output int cycles);
      logic [31:0] w, r_s, r_t, res, ea;
      logic [5:0]  op, fn;
      logic [4:0]  dst;
      logic        wr;
      cycles = 0;
      m_pc   = 32'd0;
      for (int n = 0; n < 2000 && m_pc != halt; n++) begin
         w   = m_mem[m_pc[9:0]];
         op  = w[31:26];
         fn  = w[5:0];
         r_s = m_reg[w[25:21]];
         r_t = m_reg[w[20:16]];
         ea  = r_s + sx(w[15:0]);
         m_pc = m_pc + 32'd1;
         wr  = 1'b0;
         dst = 5'd0;
         res = 32'd0;
         cycles += 2;
         case (op)
            6'h00: begin
               wr  = 1'b1;
               dst = w[15:11];
               cycles += 2;
               case (fn)
                  6'h20: res = r_s + r_t;
                  6'h22: res = r_s - r_t;
                  6'h24: res = r_s & r_t;
                  6'h25: res = r_s | r_t;
                  6'h2A: res = ($signed(r_s) < $signed(r_t)) ? 32'd1 : 32'd0;
`ifdef MIPS_SHIFT_EN
                  6'h00: res = r_t << w[10:6];
                  6'h06: res = r_t >> r_s[4:0];
`endif
                  default: begin
                     wr = 1'b0;
                     cycles -= 2;
                  end
               endcase
            end
            6'h08: begin wr = 1'b1; dst = w[20:16]; res = ea; cycles += 2; end
            6'h23: begin wr = 1'b1; dst = w[20:16]; res = m_mem[ea[9:0]]; cycles += 3; end
            6'h2B: begin m_mem[ea[9:0]] = r_t; cycles += 2; end
            6'h04: begin
               if (r_s == r_t) m_pc = m_pc + sx(w[15:0]);
               cycles += 1;
            end
            6'h02: begin m_pc = {m_pc[31:26], w[25:0]}; cycles += 1; end
            default: ;
         endcase
         if (wr && dst != 5'd0) m_reg[dst] = res;
      end
   endtask

   // Random instruction at index i; control flow only moves forward, up to n.
   function automatic logic [31:0] rand_instr(input int i, input int n);
      logic [4:0]  rs, rt, rd, sh;
      logic [5:0]  fns [8];
      int          span;
      fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h06, 6'h21};
      rs   = 5'($urandom_range(0, 7));
      rt   = 5'($urandom_range(0, 7));
      rd   = 5'($urandom_range(0, 7));
      sh   = 5'($urandom_range(0, 31));
      span = n - 1 - i;
      if (span > 2) span = 2;
      case ($urandom_range(0, 8))
         0, 1:    return {6'h08, rs, rt, 16'($urandom)};
         2, 3:    return {6'h00, rs, rt, rd, sh, fns[$urandom_range(0, 7)]};
         4:       return {6'h23, 5'd0, rt, 16'(600 + $urandom_range(0, 15))};
         5:       return {6'h2B, 5'd0, rt, 16'(600 + $urandom_range(0, 15))};
         6:       return {6'h04, rs, rt, 16'($urandom_range(0, span))};
         7:       return {6'h02, 26'(i + 1 + $urandom_range(0, span))};
         default: return {6'h3F, 26'($urandom)};
      endcase
   endfunction

   initial begin
      int cyc;
      int bad;
      int n;

      vecs[0]  = '{"add",       16'd5,      16'd7,      32'h00221820, 3, 32'd12,        4};
      vecs[1]  = '{"sub",       16'd5,      16'd7,      32'h00221822, 3, 32'hFFFFFFFE,  4};
      vecs[2]  = '{"and",       16'h0F0F,   16'h00FF,   32'h00221824, 3, 32'h0000000F,  4};
      vecs[3]  = '{"or",        16'h0F0F,   16'h00FF,   32'h00221825, 3, 32'h00000FFF,  4};
      vecs[4]  = '{"slt_neg",   16'hFFFF,   16'd1,      32'h0022182A, 3, 32'd1,         4};
      vecs[5]  = '{"slt_pos",   16'd1,      16'hFFFF,   32'h0022182A, 3, 32'd0,         4};
      vecs[6]  = '{"addi_neg",  16'd2,      16'd0,      32'h2023FFFD, 3, 32'hFFFFFFFF,  4};
      vecs[7]  = '{"lw",        16'd0,      16'd0,      32'h8C030258, 3, 32'hCAFEBABE,  5};
      vecs[8]  = '{"sub_wrap",  16'h8000,   16'd1,      32'h00221822, 3, 32'hFFFF7FFF,  4};
      vecs[9]  = '{"add_wrap",  16'hFFFF,   16'd1,      32'h00221820, 3, 32'd0,         4};
      vecs[10] = '{"bad_funct", 16'd5,      16'd7,      32'h00221821, 3, 32'd0,         2};
      vecs[11] = '{"bad_op",    16'd5,      16'd7,      32'h3C031234, 3, 32'd0,         2};
      vecs[12] = '{"add_r0",    16'd5,      16'd7,      32'h00220020, 0, 32'd0,         4};

      // ---------------- vector table ----------------
      for (int v = 0; v < 13; v++) begin
         clear_img();
         img[0]   = {16'h2001, vecs[v].a};
         img[1]   = {16'h2002, vecs[v].b};
         img[2]   = vecs[v].instr;
         img[3]   = HALT;
         img[600] = 32'hCAFEBABE;
         start_prog();
         run(8 + vecs[v].cyc - 1);
         check({vecs[v].name, " busy"}, in_fetch(), 32'd0);
         run(1);
         check({vecs[v].name, " done"}, in_fetch(), 32'd1);
         check({vecs[v].name, " pc"}, dut.DP.pc_q, 32'd3);
         check({vecs[v].name, " rd"}, dut.DP.regs_q[vecs[v].dst], vecs[v].exp);
      end

      // ---------------- random programs vs reference model ----------------
      for (int t = 0; t < 12; t++) begin
         n = 14;
         clear_img();
         for (int i = 600; i < 616; i++) img[i] = $urandom;
         for (int i = 0; i < n; i++) img[i] = rand_instr(i, n);
         img[n] = HALT;
         for (int i = 0; i < 1024; i++) m_mem[i] = img[i];
         for (int r = 0; r < 32; r++) m_reg[r] = 32'd0;
         model_run(n, cyc);
         start_prog();
         run(cyc);
         check($sformatf("rand%0d pc", t), dut.DP.pc_q, 32'(n));
         check($sformatf("rand%0d fetch", t), in_fetch(), 32'd1);
         for (int r = 0; r < 8; r++)
            check($sformatf("rand%0d reg%0d", t, r), dut.DP.regs_q[r], m_reg[r]);
         for (int a = 600; a < 616; a++)
            check($sformatf("rand%0d mem%0d", t, a), dut.DP.RAM.mem_space[a], m_mem[a]);
      end

      // ---------------- latency: addi then lw ----------------
      clear_img();
      img[0]   = 32'h20010007;
      img[1]   = 32'h8C020258;
      img[2]   = HALT;
      img[600] = 32'h12345678;
      start_prog();
      run(3);
      check("addi before wb", dut.DP.regs_q[1], 32'd0);
      run(1);
      check("addi at cycle 4", dut.DP.regs_q[1], 32'd7);
      run(4);
      check("lw before wb", dut.DP.regs_q[2], 32'd0);
      run(1);
      check("lw at cycle 5", dut.DP.regs_q[2], 32'h12345678);

      // ---------------- branch / jump ----------------
      clear_img();
      img[0]  = 32'h20010001;
      img[1]  = 32'h10200005;
      img[2]  = 32'h08000008;
      img[8]  = 32'h10000007;
      img[16] = 32'h08000007;
      img[7]  = HALT;
      start_prog();
      run(7);
      check("beq not taken pc", dut.DP.pc_q, 32'd2);
      run(3);
      check("j 8 pc", dut.DP.pc_q, 32'd8);
      run(3);
      check("beq taken pc", dut.DP.pc_q, 32'd16);
      run(3);
      check("j 7 pc", dut.DP.pc_q, 32'd7);

      // ---------------- $0 protection ----------------
      clear_img();
      img[0] = 32'h20010009;
      img[1] = 32'h20000005;
      img[2] = 32'h00000820;
      img[3] = HALT;
      start_prog();
      run(4);
      check("r0 setup r1", dut.DP.regs_q[1], 32'd9);
      run(4);
      check("r0 after addi", dut.DP.regs_q[0], 32'd0);
      run(4);
      check("r1 from r0+r0", dut.DP.regs_q[1], 32'd0);

      // ---------------- reset during MEMWRITE ----------------
      clear_img();
      img[0]   = 32'h20010009;
      img[1]   = 32'hAC010258;
      img[2]   = HALT;
      img[600] = 32'h0BADF00D;
      start_prog();
      run(7);
      check("in memwrite", {28'd0, dut.CU.state_q}, {28'd0, ST_MEMWRITE});
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("async pc clear", dut.DP.pc_q, 32'd0);
      run(2);
      check("memwrite suppressed", dut.DP.RAM.mem_space[600], 32'h0BADF00D);
      check("memwrite rst pc", dut.DP.pc_q, 32'd0);
      check("memwrite rst fetch", in_fetch(), 32'd1);

      // ---------------- reset hold with Fibonacci image, then run ----------------
      clear_img();
      img[0]  = 32'h00000000; img[1]  = 32'h20190200; img[2]  = 32'h00008020;
      img[3]  = 32'h20110001; img[4]  = 32'h8F37000F; img[5]  = 32'h20160001;
      img[6]  = 32'h00007820; img[7]  = 32'h01F7402A; img[8]  = 32'h10080007;
      img[9]  = 32'h02119020; img[10] = 32'hAF310001; img[11] = 32'hAF320002;
      img[12] = 32'h8F300001; img[13] = 32'h8F310002; img[14] = 32'h01F67820;
      img[15] = 32'h08000007; img[16] = 32'h02308022; img[17] = 32'hAF300000;
      img[18] = 32'h1000FFFF; img[19] = 32'h02309024; img[20] = 32'h02309025;
      img[21] = 32'h02D29006;
      img[527] = 32'd5;
      // Leave registers dirty first so the reset clear is observable.
      start_prog();
      run(12);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 1024; i++) dut.DP.RAM.mem_space[i] = img[i];
      repeat (3) @(posedge clk);
      #1;
      check("reset pc", dut.DP.pc_q, 32'd0);
      check("reset fetch", in_fetch(), 32'd1);
      check("reset ir", dut.DP.ir_q, 32'd0);
      bad = 0;
      for (int r = 0; r < 32; r++) if (dut.DP.regs_q[r] !== 32'd0) bad++;
      check("reset regs nonzero", 32'(bad), 32'd0);
      bad = 0;
      for (int i = 0; i < 1024; i++) if (dut.DP.RAM.mem_space[i] !== img[i]) bad++;
      check("reset mem changed", 32'(bad), 32'd0);

      @(negedge clk);
      rst = 1'b1;
      run(300);
      check("fib mem513", dut.DP.RAM.mem_space[513], 32'd5);
      check("fib mem514", dut.DP.RAM.mem_space[514], 32'd8);
      check("fib mem512", dut.DP.RAM.mem_space[512], 32'd3);
      check("fib r16", dut.DP.regs_q[16], 32'd3);
      check("fib r17", dut.DP.regs_q[17], 32'd8);
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         if (dut.DP.pc_q != 32'd18 && dut.DP.pc_q != 32'd19) bad++;
         run(1);
      end
      check("fib halt pc off", 32'(bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
